// File: rtl/mux_large_pkg.sv
// Shared types and defaults for the pipelined wide channel mux.
// Buffer occupancy states and the default payload layout.
package mux_large_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NUM_CH = 10;
  localparam int DEF_SEL_W  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_SEL_W-1:0] ch;
    logic                 err;
  } payload_t;

endpackage

// File: rtl/mux_large_if.sv
// Request/response bundle of the pipelined channel mux.
// master drives requests and out_ready; slave is the mux.
interface mux_large_if
  import mux_large_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W
);
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    mode;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, mode, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_err, out_valid
  );

  modport slave (
    input  in_data, in_sel, mode, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_err, out_valid
  );
endinterface

// File: rtl/mux_skid_buf.sv
// Generic 2-entry valid/ready skid buffer, FIFO order.
// in_ready depends only on the state register.
module mux_skid_buf
  import mux_large_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);
  buf_state_e    state;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          acc;
  logic          pop;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            skid_q <= in_data;
            state  <= TWO;
          end else if (acc) begin
            main_q <= in_data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/mux_large_pipe.sv
// NUM_CH x WIDTH channel mux with out-of-range fallback to ch0,
// round-robin scan mode and a registered skid-buffered output.
module mux_large_pipe
  import mux_large_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_large_if.slave  bus
);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] ch;
    logic             err;
  } pl_t;

  localparam int DW = $bits(pl_t);
  localparam logic [SEL_W:0]   NCH  = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0] scan_ptr;
  logic [SEL_W-1:0] eff_sel;
  logic             err;
  logic [WIDTH-1:0] sel_data;
  logic             acc;
  pl_t              pl_in;
  pl_t              pl_out;
  logic [DW-1:0]    out_bits;

  assign eff_sel = bus.mode ? scan_ptr : bus.in_sel;
  assign err     = ({1'b0, eff_sel} >= NCH);
  assign acc     = bus.in_valid & bus.in_ready;

  // Default is ch0, which is also the out-of-range substitute
  always_comb begin
    sel_data = bus.in_data[WIDTH-1:0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (eff_sel == SEL_W'(k))
        sel_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  assign pl_in.data = sel_data;
  assign pl_in.ch   = err ? '0 : eff_sel;
  assign pl_in.err  = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      scan_ptr <= '0;
    else if (!bus.mode)
      scan_ptr <= '0;
    else if (acc)
      scan_ptr <= (scan_ptr == LAST) ? '0 : scan_ptr + 1'b1;
  end

  mux_skid_buf #(.DW(DW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (pl_in),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_data  (out_bits),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  assign pl_out       = pl_t'(out_bits);
  assign bus.out_data = pl_out.data;
  assign bus.out_ch   = pl_out.ch;
  assign bus.out_err  = pl_out.err;
endmodule

// File: tb/tb_mux_large_pipe.sv
// Directed and scoreboarded checks of the pipelined channel mux,
// default build plus a NUM_CH=5/SEL_W=3/WIDTH=16 build.
module tb_mux_large_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mux_large_if #(.WIDTH(8), .NUM_CH(10), .SEL_W(4)) ia ();
  mux_large_if #(.WIDTH(16), .NUM_CH(5), .SEL_W(3)) ib ();

  mux_large_pipe #(.WIDTH(8), .NUM_CH(10), .SEL_W(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  mux_large_pipe #(.WIDTH(16), .NUM_CH(5), .SEL_W(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  logic [7:0]  cha [10];
  logic [15:0] chb [5];
  logic [19:0] q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a;
    for (int k = 0; k < 10; k++) ia.in_data[k*8 +: 8] = cha[k];
  endtask

  task automatic chk_a(input string tag, input logic [7:0] d,
                       input logic [3:0] ch, input logic e);
    chk({tag, "_v"}, ia.out_valid, 1);
    chk({tag, "_d"}, ia.out_data, d);
    chk({tag, "_ch"}, ia.out_ch, ch);
    chk({tag, "_err"}, ia.out_err, e);
  endtask

  initial begin
    logic        stall;
    logic        acc;
    logic [19:0] held;
    logic [19:0] cur;
    logic [19:0] exp;
    int          sp;
    int          eff;

    ia.in_sel = '0; ia.mode = 0; ia.in_valid = 0; ia.out_ready = 0;
    ib.in_sel = '0; ib.mode = 0; ib.in_valid = 0; ib.out_ready = 0;
    ib.in_data = '0;
    for (int k = 0; k < 10; k++) cha[k] = 8'h10 + 8'(k);
    drive_a;

    // reset state
    #12;
    chk("rst_ov", ia.out_valid, 0);
    chk("rst_ir", ia.in_ready, 1);
    chk("rst_d", ia.out_data, 0);
    chk("rst_ch", ia.out_ch, 0);
    chk("rst_err", ia.out_err, 0);
    @(negedge clk) rst_n = 1'b1;
    step;

    // explicit select sweep, back to back
    ia.out_ready = 1;
    ia.in_valid = 1;
    ia.in_sel = 4'd0;
    for (int k = 1; k < 10; k++) begin
      step;
      chk_a("sweep", 8'h10 + 8'(k - 1), 4'(k - 1), 0);
      chk("sweep_ir", ia.in_ready, 1);
      ia.in_sel = 4'(k);
    end
    step;
    chk_a("sweep_last", 8'h19, 4'd9, 0);

    // out-of-range selects
    cha[0] = 8'hA5;
    drive_a;
    ia.in_sel = 4'd12;
    step;
    chk_a("oor12", 8'hA5, 4'd0, 1);
    ia.in_sel = 4'd15;
    step;
    chk_a("oor15", 8'hA5, 4'd0, 1);
    cha[0] = 8'h10;
    drive_a;
    ia.in_valid = 0;
    step;
    chk("idle_ov", ia.out_valid, 0);

    // backpressure
    ia.out_ready = 0;
    ia.in_valid = 1;
    ia.in_sel = 4'd1;
    step;
    chk("bp1_ir", ia.in_ready, 1);
    ia.in_sel = 4'd2;
    step;
    chk("bp2_ir", ia.in_ready, 0);
    chk_a("bp2", 8'h11, 4'd1, 0);
    ia.in_sel = 4'd3;
    step;
    chk("bp3_ir", ia.in_ready, 0);
    chk_a("bp3_hold", 8'h11, 4'd1, 0);
    ia.out_ready = 1;
    step;
    chk("bp4_ir", ia.in_ready, 1);
    chk_a("bp4", 8'h12, 4'd2, 0);
    step;
    chk_a("bp5", 8'h13, 4'd3, 0);
    ia.in_valid = 0;
    step;
    chk("bp6_ov", ia.out_valid, 0);

    // scan mode
    ia.mode = 1;
    ia.in_valid = 1;
    ia.in_sel = 4'd7;
    for (int i = 0; i < 12; i++) begin
      step;
      chk_a("scan", cha[i % 10], 4'(i % 10), 0);
    end
    ia.mode = 0;
    ia.in_sel = 4'd3;
    step;
    chk_a("scan_m0", 8'h13, 4'd3, 0);
    ia.mode = 1;
    step;
    chk_a("scan_r0", 8'h10, 4'd0, 0);
    step;
    chk_a("scan_r1", 8'h11, 4'd1, 0);
    ia.in_valid = 0;
    ia.mode = 0;
    step;

    // reset while full
    ia.out_ready = 0;
    ia.in_valid = 1;
    ia.in_sel = 4'd7;
    step;
    step;
    chk("full_ir", ia.in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ov", ia.out_valid, 0);
    chk("mrst_ir", ia.in_ready, 1);
    chk("mrst_d", ia.out_data, 0);
    chk("mrst_ch", ia.out_ch, 0);
    chk("mrst_err", ia.out_err, 0);
    ia.out_ready = 1;
    step;
    chk("mrst_hold", ia.out_valid, 0);
    ia.in_valid = 0;
    @(negedge clk) rst_n = 1'b1;
    step;
    chk("post_rst_ov", ia.out_valid, 0);

    // random traffic vs scoreboard on the small build
    stall = 0;
    held = '0;
    sp = 0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        ib.in_valid  = ($urandom % 4) != 0;
        ib.out_ready = ($urandom % 3) != 0;
      end else begin
        ib.in_valid  = 0;
        ib.out_ready = 1;
      end
      ib.mode   = ($urandom % 5) == 0;
      ib.in_sel = 3'($urandom_range(0, 7));
      for (int k = 0; k < 5; k++) begin
        chb[k] = 16'($urandom);
        ib.in_data[k*16 +: 16] = chb[k];
      end
      cur = {ib.out_data, ib.out_ch, ib.out_err};
      if (stall) begin
        chk("stall_v", ib.out_valid, 1);
        chk("stall_hold", cur, held);
      end
      if (ib.out_valid && ib.out_ready) begin
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) chk("sb_pl", cur, q.pop_front());
      end
      stall = ib.out_valid && !ib.out_ready;
      held = cur;
      acc = ib.in_valid && ib.in_ready;
      if (acc) begin
        eff = ib.mode ? sp : int'(ib.in_sel);
        if (eff >= 5) exp = {chb[0], 3'd0, 1'b1};
        else exp = {chb[eff], 3'(eff), 1'b0};
        q.push_back(exp);
      end
      if (!ib.mode) sp = 0;
      else if (acc) sp = (sp == 4) ? 0 : sp + 1;
      step;
    end
    chk("sb_drained", q.size(), 0);
    chk("sb_end_ov", ib.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
